// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared definitions for the key debouncer: channel FSM state
//               encoding, 50 MHz default timing constants and parameter
//               legality helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

  // Per-channel FSM states
  typedef enum logic [1:0] {
    KEY_IDLE       = 2'd0,
    KEY_PRESS_DB   = 2'd1,
    KEY_HELD       = 2'd2,
    KEY_RELEASE_DB = 2'd3
  } key_fsm_e;

  // Default timing at 50 MHz: 20 ms debounce, 1 s long press, 200 ms repeat
  localparam int KEY_DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int KEY_DEF_LONG_CYC     = 50_000_000;
  localparam int KEY_DEF_REPEAT_CYC   = 10_000_000;

  // Larger of two cycle counts, used to size the shared hold counter
  function automatic int key_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Debounce needs at least a 1-bit counter, long press at least one cycle,
  // repeat period may be zero (disabled) but never negative.
  function automatic bit key_params_ok(input int n_keys, input int debounce_cyc,
                                       input int long_cyc, input int repeat_cyc);
    return (n_keys >= 1) && (debounce_cyc >= 2) && (long_cyc >= 1) && (repeat_cyc >= 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_channel.sv
`default_nettype none
// ============================================================================
// Module      : key_channel
// Description : One key channel: 2-FF synchroniser, polarity normalisation,
//               press/release debounce FSM, hold counter for long-press and
//               auto-repeat pulses. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = KEY_DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = KEY_DEF_LONG_CYC,
  parameter int REPEAT_CYC   = KEY_DEF_REPEAT_CYC,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_W = $clog2(key_max(LONG_CYC, REPEAT_CYC) + 1);

  // Terminal counts: a counter sitting at *_LAST on an active edge completes
  // its interval on that edge.
  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYC - 1);
  // Only meaningful when REPEAT_CYC is non-zero; the repeat branch is
  // guarded by that condition.
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYC - 1);

  // Released pin level, used to preset the synchroniser so reset never
  // looks like a press.
  localparam logic [1:0] SYNC_IDLE = {2{ACTIVE_LOW}};

  logic [1:0]        sync_q, sync_d;
  key_fsm_e          state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              key_state_q, key_state_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;
  logic              key_s;

  // Synchroniser shift and polarity normalisation (key_s = 1 when pressed)
  always_comb begin
    sync_d = {sync_q[0], key_in};
    key_s  = sync_q[1] ^ ACTIVE_LOW;
  end

  // Next-state, counter and pulse logic for the debounce/hold FSM
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      KEY_IDLE: begin
        key_state_d = 1'b0;
        if (key_s) begin
          state_d  = KEY_PRESS_DB;
          db_cnt_d = '0;
        end
      end

      KEY_PRESS_DB: begin
        if (!key_s) begin
          state_d = KEY_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = KEY_HELD;
          press_d     = 1'b1;
          key_state_d = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      KEY_HELD: begin
        // A release takes priority; the hold count does not advance on the
        // edge that leaves HELD, so RELEASE_DB time shifts later pulses.
        if (!key_s) begin
          state_d  = KEY_RELEASE_DB;
          db_cnt_d = '0;
        end else if (!long_done_q) begin
          if (hold_cnt_q == LONG_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            hold_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end else if (REPEAT_CYC != 0) begin
          // Counter reloads each repeat period, so it never wraps.
          if (hold_cnt_q == REPEAT_LAST) begin
            repeat_d   = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        // With repeat disabled the count simply stays frozen after long.
      end

      KEY_RELEASE_DB: begin
        // Hold count frozen here; a bounce back resumes it unchanged.
        if (key_s) begin
          state_d = KEY_HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = KEY_IDLE;
          release_d   = 1'b1;
          key_state_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = KEY_IDLE;
        key_state_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any press without a release
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q      <= SYNC_IDLE;
      state_q     <= KEY_IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign key_state     = key_state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule
`default_nettype wire

// File: rtl/key_scan_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_debounce
// Description : N-channel push-button debouncer and event generator. Each
//               key is handled by an independent key_channel instance.
// Revision    : 1.0 - initial release
// ============================================================================
module key_scan_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = KEY_DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = KEY_DEF_LONG_CYC,
  parameter int REPEAT_CYC   = KEY_DEF_REPEAT_CYC,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  // Reject illegal timing parameters at elaboration
  if (!key_params_ok(N_KEYS, DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)) begin : g_param_error
    $error("key_scan_debounce: illegal parameters (N_KEYS>=1, DEBOUNCE_CYC>=2, LONG_CYC>=1, REPEAT_CYC>=0)");
  end

  // One independent channel per key, bit-sliced onto the port vectors
  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .key_in        (key_in[i]),
      .key_state     (key_state[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_key_scan_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_scan_debounce
// Description : Directed self-checking bench for key_scan_debounce with
//               DEBOUNCE_CYC=8, LONG_CYC=32, REPEAT_CYC=10 (plus a second
//               instance with REPEAT_CYC=0). Edge indices are relative to the
//               edge at which a test's first pin change is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_scan_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic [3:0] nr_key_state, nr_press, nr_release, nr_long, nr_repeat;

  int n_tests;
  int n_fail;

  // Event log filled by record()
  int press_n[4], press_at[4], press_last[4];
  int rel_n[4], rel_at[4];
  int long_n[4], long_at[4];
  int rep_n[4];
  int rep_at[4][8];
  int nr_long_n[4], nr_long_at[4], nr_rep_n[4];
  int overlap_n;

  key_scan_debounce #(
    .N_KEYS(4), .DEBOUNCE_CYC(8), .LONG_CYC(32), .REPEAT_CYC(10), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  key_scan_debounce #(
    .N_KEYS(4), .DEBOUNCE_CYC(8), .LONG_CYC(32), .REPEAT_CYC(0), .ACTIVE_LOW(1'b1)
  ) dut_norep (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_state(nr_key_state), .press_pulse(nr_press), .release_pulse(nr_release),
    .long_pulse(nr_long), .repeat_pulse(nr_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    for (int i = 0; i < 4; i++) begin
      press_n[i] = 0; press_at[i] = -1; press_last[i] = -1;
      rel_n[i] = 0; rel_at[i] = -1;
      long_n[i] = 0; long_at[i] = -1;
      rep_n[i] = 0;
      for (int j = 0; j < 8; j++) rep_at[i][j] = -1;
      nr_long_n[i] = 0; nr_long_at[i] = -1; nr_rep_n[i] = 0;
    end
    overlap_n = 0;
  endtask

  task automatic record(input int e);
    for (int i = 0; i < 4; i++) begin
      if (press_pulse[i]) begin
        if (press_n[i] == 0) press_at[i] = e;
        press_last[i] = e;
        press_n[i]++;
      end
      if (release_pulse[i]) begin
        if (rel_n[i] == 0) rel_at[i] = e;
        rel_n[i]++;
      end
      if (long_pulse[i]) begin
        if (long_n[i] == 0) long_at[i] = e;
        long_n[i]++;
      end
      if (repeat_pulse[i]) begin
        if (rep_n[i] < 8) rep_at[i][rep_n[i]] = e;
        rep_n[i]++;
      end
      if (press_pulse[i] && release_pulse[i]) overlap_n++;
      if (nr_long[i]) begin
        if (nr_long_n[i] == 0) nr_long_at[i] = e;
        nr_long_n[i]++;
      end
      if (nr_repeat[i]) nr_rep_n[i]++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_in = 4'hF;
    for (int c = 0; c < 3; c++) step();
    n_tests++;
    if ({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {key_state, press_pulse, release_pulse, long_pulse, repeat_pulse});
    end
    n_tests++;
    if ({nr_key_state, nr_press, nr_release, nr_long, nr_repeat} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_norep: got %h expected 0",
               {nr_key_state, nr_press, nr_release, nr_long, nr_repeat});
    end
    rst = 1'b1;
    clear_events();
    for (int e = 0; e < 12; e++) begin
      step();
      record(e);
    end
    n_tests++;
    if (key_state !== 4'h0 || press_n[0] + press_n[1] + press_n[2] + press_n[3] != 0) begin
      n_fail++;
      $display("FAIL reset_release_idle: key_state %b presses %0d expected 0000 and 0",
               key_state, press_n[0] + press_n[1] + press_n[2] + press_n[3]);
    end
  endtask

  task automatic test_clean_press();
    logic ks9, ks10, ks60;
    ks9 = 1'bx; ks10 = 1'bx; ks60 = 1'bx;
    clear_events();
    for (int e = 0; e < 66; e++) begin
      if (e == 0)  key_in[0] = 1'b0;
      if (e == 50) key_in[0] = 1'b1;
      step();
      record(e);
      if (e == 9)  ks9  = key_state[0];
      if (e == 10) ks10 = key_state[0];
      if (e == 60) ks60 = key_state[0];
    end
    n_tests++;
    if (press_n[0] != 1 || press_at[0] != 10) begin
      n_fail++;
      $display("FAIL clean_press_pulse: got count %0d at edge %0d expected 1 at edge 10", press_n[0], press_at[0]);
    end
    n_tests++;
    if (ks9 !== 1'b0 || ks10 !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_press_state: got %b/%b at edges 9/10 expected 0/1", ks9, ks10);
    end
    n_tests++;
    if (rel_n[0] != 1 || rel_at[0] != 60 || ks60 !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_release: got count %0d at edge %0d state %b expected 1 at edge 60 state 0",
               rel_n[0], rel_at[0], ks60);
    end
    n_tests++;
    if (press_n[1] + press_n[2] + press_n[3] != 0 || overlap_n != 0) begin
      n_fail++;
      $display("FAIL clean_press_isolation: got other presses %0d overlaps %0d expected 0 and 0",
               press_n[1] + press_n[2] + press_n[3], overlap_n);
    end
  endtask

  task automatic test_glitch();
    logic ever_on;
    ever_on = 1'b0;
    clear_events();
    for (int e = 0; e < 30; e++) begin
      if (e == 0) key_in[1] = 1'b0;
      if (e == 5) key_in[1] = 1'b1;
      step();
      record(e);
      if (key_state[1]) ever_on = 1'b1;
    end
    n_tests++;
    if (press_n[1] != 0 || rel_n[1] != 0 || ever_on !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_filtered: got press %0d release %0d state_seen %b expected 0 0 0",
               press_n[1], rel_n[1], ever_on);
    end
  endtask

  task automatic test_bounce();
    clear_events();
    for (int e = 0; e < 60; e++) begin
      // Press bounce: low 3, high 2, steady low from edge 5
      if (e == 0)  key_in[1] = 1'b0;
      if (e == 3)  key_in[1] = 1'b1;
      if (e == 5)  key_in[1] = 1'b0;
      // Release bounce: high 3, low 2, steady high from edge 35
      if (e == 30) key_in[1] = 1'b1;
      if (e == 33) key_in[1] = 1'b0;
      if (e == 35) key_in[1] = 1'b1;
      step();
      record(e);
    end
    n_tests++;
    if (press_n[1] != 1 || press_at[1] != 15) begin
      n_fail++;
      $display("FAIL bounce_press: got count %0d at edge %0d expected 1 at edge 15", press_n[1], press_at[1]);
    end
    n_tests++;
    if (rel_n[1] != 1 || rel_at[1] != 45) begin
      n_fail++;
      $display("FAIL bounce_release: got count %0d at edge %0d expected 1 at edge 45", rel_n[1], rel_at[1]);
    end
  endtask

  task automatic test_long_repeat();
    clear_events();
    // Press pulse H=10; released pin sampled at 88 so RELEASE_DB starts at 90
    for (int e = 0; e < 110; e++) begin
      if (e == 0)  key_in[2] = 1'b0;
      if (e == 88) key_in[2] = 1'b1;
      step();
      record(e);
    end
    n_tests++;
    if (press_n[2] != 1 || press_at[2] != 10) begin
      n_fail++;
      $display("FAIL long_press_edge: got count %0d at edge %0d expected 1 at edge 10", press_n[2], press_at[2]);
    end
    n_tests++;
    if (long_n[2] != 1 || long_at[2] != 42) begin
      n_fail++;
      $display("FAIL long_pulse: got count %0d at edge %0d expected 1 at edge 42", long_n[2], long_at[2]);
    end
    n_tests++;
    if (rep_n[2] != 4 || rep_at[2][0] != 52 || rep_at[2][1] != 62 ||
        rep_at[2][2] != 72 || rep_at[2][3] != 82) begin
      n_fail++;
      $display("FAIL repeat_pulses: got count %0d at %0d,%0d,%0d,%0d expected 4 at 52,62,72,82",
               rep_n[2], rep_at[2][0], rep_at[2][1], rep_at[2][2], rep_at[2][3]);
    end
    n_tests++;
    if (rel_n[2] != 1 || rel_at[2] != 98) begin
      n_fail++;
      $display("FAIL long_release: got count %0d at edge %0d expected 1 at edge 98", rel_n[2], rel_at[2]);
    end
    n_tests++;
    if (nr_long_n[2] != 1 || nr_long_at[2] != 42 || nr_rep_n[2] != 0) begin
      n_fail++;
      $display("FAIL norepeat: got long %0d at edge %0d repeats %0d expected 1 at edge 42 and 0",
               nr_long_n[2], nr_long_at[2], nr_rep_n[2]);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] ks10;
    ks10 = 4'hx;
    clear_events();
    for (int e = 0; e < 45; e++) begin
      if (e == 0)  begin key_in[1] = 1'b0; key_in[3] = 1'b0; end
      if (e == 20) begin key_in[1] = 1'b1; key_in[3] = 1'b1; end
      step();
      record(e);
      if (e == 10) ks10 = key_state;
    end
    n_tests++;
    if (press_at[1] != 10 || press_at[3] != 10 || press_n[1] != 1 || press_n[3] != 1) begin
      n_fail++;
      $display("FAIL simul_press: got key1 %0d@%0d key3 %0d@%0d expected 1@10 for both",
               press_n[1], press_at[1], press_n[3], press_at[3]);
    end
    n_tests++;
    if (ks10 !== 4'b1010 || press_n[0] != 0 || press_n[2] != 0) begin
      n_fail++;
      $display("FAIL simul_state: got %b idle presses %0d/%0d expected 1010 and 0/0",
               ks10, press_n[0], press_n[2]);
    end
    n_tests++;
    if (rel_at[1] != 30 || rel_at[3] != 30) begin
      n_fail++;
      $display("FAIL simul_release: got edges %0d/%0d expected 30/30", rel_at[1], rel_at[3]);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [19:0] outs20;
    outs20 = 20'hx;
    clear_events();
    for (int e = 0; e < 56; e++) begin
      if (e == 0)  key_in[0] = 1'b0;
      if (e == 20) rst = 1'b0;
      if (e == 23) rst = 1'b1;
      if (e == 40) key_in[0] = 1'b1;
      step();
      record(e);
      if (e == 20) outs20 = {key_state, press_pulse, release_pulse, long_pulse, repeat_pulse};
    end
    n_tests++;
    if (outs20 !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid_hold_outputs: got %h expected 0", outs20);
    end
    n_tests++;
    if (press_n[0] != 2 || press_at[0] != 10 || press_last[0] != 33) begin
      n_fail++;
      $display("FAIL reset_mid_hold_repress: got count %0d first %0d last %0d expected 2 10 33",
               press_n[0], press_at[0], press_last[0]);
    end
    n_tests++;
    if (rel_n[0] != 1 || rel_at[0] != 50) begin
      n_fail++;
      $display("FAIL reset_mid_hold_release: got count %0d at edge %0d expected 1 at edge 50",
               rel_n[0], rel_at[0]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    key_in  = 4'hF;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_long_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_scan_debounce.md
# key_scan_debounce

Multi-channel key debouncer and event generator for front-panel push-buttons. Each of `N_KEYS` raw inputs is synchronised, debounced symmetrically on press and release, and turned into a debounced level plus single-cycle press, release, long-press and auto-repeat pulses. It sits between the board key pins and the control FSMs and replaces per-key single-edge filters.

## Interface

- `N_KEYS`, default 4: number of independent key channels.
- `DEBOUNCE_CYC`, default 1_000_000: stable cycles required to accept a level change (20 ms at 50 MHz). Must be at least 2.
- `LONG_CYC`, default 50_000_000: held cycles, counted from the press pulse, before `long_pulse` (1 s). Must be at least 1.
- `REPEAT_CYC`, default 10_000_000: period of `repeat_pulse` after a long press (200 ms). A value of 0 disables repeat.
- `ACTIVE_LOW`, default 1: when 1, a pin at 0 means pressed.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-low.
- `key_in` input N_KEYS: raw asynchronous key pins.
- `key_state` output N_KEYS: debounced level, 1 = pressed.
- `press_pulse` output N_KEYS: 1-cycle pulse when a press is accepted.
- `release_pulse` output N_KEYS: 1-cycle pulse when a release is accepted.
- `long_pulse` output N_KEYS: 1-cycle pulse once per press, after `LONG_CYC`.
- `repeat_pulse` output N_KEYS: periodic 1-cycle pulses while a long press is held.

## Operation

- Each channel has a 2-FF synchroniser followed by polarity normalisation, giving `s` = 1 when pressed. Channels are fully independent.
- Per-channel FSM states:
  - IDLE: `key_state`=0. If `s`=1, go to PRESS_DB and clear the debounce counter.
  - PRESS_DB: if `s`=0, return to IDLE with no output. Otherwise the counter increments; at `DEBOUNCE_CYC`-1, go to HELD, pulse `press_pulse`, set `key_state`=1, and clear the hold counter.
  - HELD: the hold counter increments each cycle.
    - When it reaches `LONG_CYC`, pulse `long_pulse` once per press.
    - After that, if `REPEAT_CYC`≠0, pulse `repeat_pulse` every `REPEAT_CYC` cycles. The counter reloads for each repeat period and never wraps.
    - If `s`=0, go to RELEASE_DB and clear the debounce counter.
  - RELEASE_DB: the hold counter is frozen and no long or repeat pulses are emitted.
    - If `s`=1, return to HELD and resume the hold count; no pulses.
    - If the counter reaches `DEBOUNCE_CYC`-1 with `s`=0, go to IDLE, pulse `release_pulse`, set `key_state`=0.
- Counter widths are `$clog2(DEBOUNCE_CYC)` for the debounce counter and `$clog2(max(LONG_CYC, REPEAT_CYC)+1)` for the hold counter.
- Reset: all outputs are 0. Synchroniser flops are preset to the released pin level. The FSM goes to IDLE and counters clear.
- Reset mid-press drops the key silently; no release pulse is generated.

## Timing

- Let P be the clock edge at which a pin change is first sampled.
  - `s` changes at P+1.
  - `press_pulse` and `key_state` rise at edge P+2+`DEBOUNCE_CYC`.
  - Release timing is the same: `release_pulse` occurs at P+2+`DEBOUNCE_CYC`, where P is the edge at which the release is first sampled.
- With H = the `press_pulse` edge:
  - `long_pulse` occurs at H+`LONG_CYC`.
  - `repeat_pulse` occurs at H+`LONG_CYC`+k·`REPEAT_CYC`, k≥1.
  - These times are shifted later by any cycles spent in RELEASE_DB.
- A glitch shorter than `DEBOUNCE_CYC` cycles at `s` produces no output.
- Press and release pulses are never in the same cycle on one channel.
- All outputs are registered. No combinational path exists from `key_in` to any output.
- A key held through reset deassertion is reported as a fresh press, using P = first edge with `rst`=1.

## Structure

- Shared package `key_pkg`, holding:
  - FSM state encodings (IDLE, PRESS_DB, HELD, RELEASE_DB);
  - default timing constants for 50 MHz;
  - the parameter legality checks.
- Sub-module `key_channel`: synchroniser, FSM and both counters for one key. It is instantiated `N_KEYS` times via generate. The top level contains only the generate loop and the port bit-slicing.

## Test plan

Use `N_KEYS`=4, `DEBOUNCE_CYC`=8, `LONG_CYC`=32, `REPEAT_CYC`=10, `ACTIVE_LOW`=1.

- Clean press: `key_in[0]` goes low, sampled at edge 0 -> `press_pulse[0]` at edge 10 and `key_state[0]`=1. Pin high sampled at edge 50 -> `release_pulse[0]` at edge 60.
- Glitch: `key_in[1]` low for 5 cycles -> no pulses, `key_state[1]` stays 0.
- Bounce: pattern of low 3, high 2, then steady low from edge 5 -> exactly one `press_pulse` at edge 15. Release bounce of equal shape -> exactly one `release_pulse`.
- Long/repeat: hold key 2 with press pulse at H -> `long_pulse` at H+32, `repeat_pulse` at H+42, H+52, H+62, H+72 for an 80-cycle hold. With `REPEAT_CYC`=0 there are no repeat pulses.
- Simultaneous keys: keys 1 and 3 are sampled low on the same edge -> both press pulses in the same cycle; keys 0 and 2 stay idle.
- Reset mid-hold: `rst`=0 while key 0 is in HELD -> all outputs 0 on the next edge, no `release_pulse`. With the key still held, `rst`=1 from edge R -> `press_pulse[0]` at R+10.
